// File: rtl/ab_req_pkg.sv
// ab_req_pkg: shared widths, pair bundle type and watchdog width
// for the A/B request pairing block.
package ab_req_pkg;

  localparam int AB_ADDR_W = 12;
  localparam int AB_DATA_W = 24;
  localparam int AB_WAIT_W = 16;

  typedef struct packed {
    logic [AB_ADDR_W-1:0] addr;
    logic [AB_DATA_W-1:0] data;
  } ab_pair_t;

endpackage

// File: rtl/ab_req_fifo.sv
// ab_req_fifo: in-order synchronous FIFO, one per request channel.
// Ports: clk, rst (sync high), i_push/i_din, i_pop, o_head,
// o_count, o_full, o_empty. Head is read from registered storage.
module ab_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_head  = r_mem[r_rp];

  // a full FIFO never accepts, even when popping this cycle
  assign w_wr = i_push && !o_full;
  assign w_rd = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wp] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_rd) begin
        r_rp <= r_rp + 1'b1;
      end
      unique case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/ab_req_pair.sv
// ab_req_pair: buffers A (address) and B (data) channels, pairs heads
// in arrival order, presents one valid/ready request.
// Ports: clk, rst (sync high); Valid_Addr/Address/Ready_Addr;
// Valid_Data/Data/Ready_Data; Req_Valid/Req_Addr/Req_Data/Req_Ready;
// Addr_Count, Data_Count occupancies; Pair_Err sticky timeout flag.
// Macro AB_REQ_PAIR_TIMEOUT_EN builds the unpaired-wait watchdog;
// without it Pair_Err is 0 and TIMEOUT is ignored.
module ab_req_pair
  import ab_req_pkg::*;
#(
  parameter int ADDR_W  = AB_ADDR_W,
  parameter int DATA_W  = AB_DATA_W,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Valid_Addr,
  input  logic [ADDR_W-1:0]      Address,
  output logic                   Ready_Addr,
  input  logic                   Valid_Data,
  input  logic [DATA_W-1:0]      Data,
  output logic                   Ready_Data,
  output logic                   Req_Valid,
  output logic [ADDR_W-1:0]      Req_Addr,
  output logic [DATA_W-1:0]      Req_Data,
  input  logic                   Req_Ready,
  output logic [$clog2(DEPTH):0] Addr_Count,
  output logic [$clog2(DEPTH):0] Data_Count,
  output logic                   Pair_Err
);

  logic w_a_full;
  logic w_a_empty;
  logic w_d_full;
  logic w_d_empty;
  logic w_a_push;
  logic w_d_push;
  logic w_pop;

  assign Ready_Addr = !rst && !w_a_full;
  assign Ready_Data = !rst && !w_d_full;
  assign w_a_push   = Valid_Addr && Ready_Addr;
  assign w_d_push   = Valid_Data && Ready_Data;
  assign Req_Valid  = !w_a_empty && !w_d_empty;
  assign w_pop      = Req_Valid && Req_Ready;

  ab_req_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_addr_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_a_push),
    .i_din   (Address),
    .i_pop   (w_pop),
    .o_head  (Req_Addr),
    .o_count (Addr_Count),
    .o_full  (w_a_full),
    .o_empty (w_a_empty)
  );

  ab_req_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_data_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_d_push),
    .i_din   (Data),
    .i_pop   (w_pop),
    .o_head  (Req_Data),
    .o_count (Data_Count),
    .o_full  (w_d_full),
    .o_empty (w_d_empty)
  );

`ifdef AB_REQ_PAIR_TIMEOUT_EN
  localparam logic [AB_WAIT_W-1:0] LP_TO = AB_WAIT_W'(TIMEOUT);

  logic [AB_WAIT_W-1:0] r_wait;
  logic [AB_WAIT_W-1:0] w_wait_nxt;
  logic                 r_err;

  // with Req_Valid low and not both empty, exactly one side waits
  always_comb begin
    w_wait_nxt = r_wait;
    if (Req_Valid || (w_a_empty && w_d_empty)) begin
      w_wait_nxt = '0;
    end else if (r_wait != LP_TO) begin
      w_wait_nxt = r_wait + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait <= '0;
      r_err  <= 1'b0;
    end else begin
      r_wait <= w_wait_nxt;
      r_err  <= r_err || (w_wait_nxt == LP_TO);
    end
  end

  assign Pair_Err = r_err;
`else
  logic w_unused_to;
  assign w_unused_to = (TIMEOUT == 0);
  assign Pair_Err    = 1'b0;
`endif

endmodule

// File: tb/tb_ab_req_pair.sv
// tb_ab_req_pair: directed + random stimulus against a queue-based
// reference model of the paired request channels.
module tb_ab_req_pair;

  localparam int AW  = 12;
  localparam int DW  = 24;
  localparam int DEP = 4;
  localparam int TO  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          Valid_Addr;
  logic [AW-1:0] Address;
  logic          Ready_Addr;
  logic          Valid_Data;
  logic [DW-1:0] Data;
  logic          Ready_Data;
  logic          Req_Valid;
  logic [AW-1:0] Req_Addr;
  logic [DW-1:0] Req_Data;
  logic          Req_Ready;
  logic [2:0]    Addr_Count;
  logic [2:0]    Data_Count;
  logic          Pair_Err;

  int qa[$];
  int qd[$];
  int m_wait;
  bit m_err;
  int n_chk;
  int n_err;

  always #5 clk = ~clk;

  ab_req_pair #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .DEPTH   (DEP),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Valid_Addr (Valid_Addr),
    .Address    (Address),
    .Ready_Addr (Ready_Addr),
    .Valid_Data (Valid_Data),
    .Data       (Data),
    .Ready_Data (Ready_Data),
    .Req_Valid  (Req_Valid),
    .Req_Addr   (Req_Addr),
    .Req_Data   (Req_Data),
    .Req_Ready  (Req_Ready),
    .Addr_Count (Addr_Count),
    .Data_Count (Data_Count),
    .Pair_Err   (Pair_Err)
  );

  function automatic bit exp_err();
`ifdef AB_REQ_PAIR_TIMEOUT_EN
    return m_err;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: drive, check outputs, advance model at the edge
  task automatic cyc(bit r, bit va, int a, bit vd, int d, bit rr);
    bit mv;
    bit pa;
    bit pd;
    rst        = r;
    Valid_Addr = va;
    Address    = a[AW-1:0];
    Valid_Data = vd;
    Data       = d[DW-1:0];
    Req_Ready  = rr;
    #1;
    mv = (qa.size() > 0) && (qd.size() > 0);
    chk("ready_addr", Ready_Addr, !r && qa.size() != DEP);
    chk("ready_data", Ready_Data, !r && qd.size() != DEP);
    chk("req_valid", Req_Valid, mv);
    if (mv) begin
      chk("req_addr", Req_Addr, qa[0]);
      chk("req_data", Req_Data, qd[0]);
    end
    chk("addr_count", Addr_Count, qa.size());
    chk("data_count", Data_Count, qd.size());
    chk("pair_err", Pair_Err, exp_err());
    @(posedge clk);
    if (r) begin
      qa.delete();
      qd.delete();
      m_wait = 0;
      m_err  = 0;
    end else begin
      if (mv || (qa.size() == 0 && qd.size() == 0)) m_wait = 0;
      else if (m_wait < TO) m_wait++;
      if (m_wait == TO) m_err = 1;
      pa = va && qa.size() != DEP;
      pd = vd && qd.size() != DEP;
      if (mv && rr) begin
        void'(qa.pop_front());
        void'(qd.pop_front());
      end
      if (pa) qa.push_back(a & 'hFFF);
      if (pd) qd.push_back(d & 'hFFFFFF);
    end
    @(negedge clk);
  endtask

  task automatic idle(int n, bit rr);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, rr);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    m_wait = 0;
    m_err = 0;
    rst = 1;
    Valid_Addr = 0;
    Address = '0;
    Valid_Data = 0;
    Data = '0;
    Req_Ready = 0;
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);

    cyc(0, 1, 'h123, 1, 'hABCDEF, 1);
    #1;
    chk("t1_valid", Req_Valid, 1);
    chk("t1_addr", Req_Addr, 'h123);
    chk("t1_data", Req_Data, 'hABCDEF);
    cyc(0, 0, 0, 0, 0, 1);
    #1;
    chk("t1_acnt0", Addr_Count, 0);
    chk("t1_dcnt0", Data_Count, 0);

    for (int i = 0; i < 5; i++) cyc(0, 1, 'h200 + i, 0, 0, 1);
    #1;
    chk("t2_full_cnt", Addr_Count, 4);
    chk("t2_full_rdy", Ready_Addr, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 'h5000 + i, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_order", Req_Addr, 'h200 + i);
      cyc(0, 0, 0, 0, 0, 1);
    end
    idle(1, 1);

    for (int i = 0; i < 10; i++)
      cyc(0, 1, 'h300 + i, 1, 'h7000 + i, i[0] == 1'b0);
    idle(12, 1);

    rst = 1;
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 1, 'h0AA, 0, 0, 1);
    idle(7, 1);
    #1;
    chk("t4_pre_err", Pair_Err, 0);
    idle(3, 1);
    cyc(0, 0, 0, 1, 'h0BB, 1);
    idle(2, 1);
    #1;
`ifdef AB_REQ_PAIR_TIMEOUT_EN
    chk("t4_err_hold", Pair_Err, 1);
`else
    chk("t4_err_hold", Pair_Err, 0);
`endif
    cyc(1, 0, 0, 0, 0, 1);
    #1;
    chk("t4_err_clr", Pair_Err, 0);

    for (int i = 0; i < 3; i++)
      cyc(0, 1, 'h400 + i, i == 0, 'h9000, 0);
    #1;
    chk("t5_acnt3", Addr_Count, 3);
    chk("t5_dcnt1", Data_Count, 1);
    cyc(1, 1, 'h4FF, 1, 'h9FFF, 0);
    cyc(1, 1, 'h4FF, 1, 'h9FFF, 1);
    cyc(0, 0, 0, 0, 0, 1);
    idle(2, 1);

    for (int i = 0; i < 400; i++)
      cyc(($urandom % 97) == 0, $urandom_range(0, 1), $urandom & 'hFFF,
          $urandom_range(0, 1), $urandom & 'hFFFFFF,
          ($urandom % 4) != 0);
    idle(8, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
